// File: rtl/gate_vector_decoder_if.sv
// Handshake bundle between a gate-vector source and gate_vector_decoder.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
interface gate_vector_decoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [0:6] vec;
    logic       out_valid;
    logic       out_ready;
    logic       out_a;
    logic       out_b;
    logic       out_err;

    modport master (
        output in_valid,
        output vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_a,
        input  out_b,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_a,
        output out_b,
        output out_err
    );
endinterface

// File: rtl/gate_vector_decoder.sv
// Recovers (a,b) from a 7-bit logic-gate result vector, flags illegal vectors,
// keeps saturating good/error counts and locks out input at an error limit.
module gate_vector_decoder #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    gate_vector_decoder_if.slave bus,
    output logic [CNT_W-1:0]     cnt_ok,
    output logic [CNT_W-1:0]     cnt_err,
    output logic                 locked,
    output logic [1:0]           dbg_state_o
);

    // Debug encoding on dbg_state_o: 0 = IDLE, 1 = RUN, 2 = LOCKED.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // A limit the counter can never reach simply never locks.
    localparam bit               LOCK_EN = (ERR_LIMIT > 0) && ($clog2(ERR_LIMIT + 1) <= CNT_W);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(ERR_LIMIT);

    state_t           state_q, state_d;
    logic             out_valid_q;
    logic             out_a_q, out_b_q, out_err_q;
    logic [CNT_W-1:0] cnt_ok_q, cnt_err_q;

    logic             in_ready;
    logic             accept;
    logic             dec_legal, dec_a, dec_b;
    logic [CNT_W-1:0] ok_inc, err_inc;
    logic             lock_hit;

    always_comb begin
        dec_legal = 1'b1;
        dec_a     = 1'b0;
        dec_b     = 1'b0;
        case (bus.vec)
            7'b1001101: begin dec_a = 1'b0; dec_b = 1'b0; end
            7'b1011010: begin dec_a = 1'b0; dec_b = 1'b1; end
            7'b0011010: begin dec_a = 1'b1; dec_b = 1'b0; end
            7'b0110001: begin dec_a = 1'b1; dec_b = 1'b1; end
            default:    dec_legal = 1'b0;
        endcase
    end

    assign accept   = bus.in_valid & in_ready;
    assign ok_inc   = (cnt_ok_q  == CNT_MAX) ? cnt_ok_q  : cnt_ok_q  + 1'b1;
    assign err_inc  = (cnt_err_q == CNT_MAX) ? cnt_err_q : cnt_err_q + 1'b1;
    assign lock_hit = LOCK_EN && !dec_legal && (err_inc == LIMIT_V);

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. clr wins over any transition caused by a same-cycle accept.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            case (state_q)
                ST_IDLE, ST_RUN: state_d = lock_hit ? ST_LOCKED : ST_RUN;
                default:         state_d = state_q;
            endcase
        end
    end

    // FSM: outputs.
    always_comb begin
        in_ready    = (state_q != ST_LOCKED) & (!out_valid_q | bus.out_ready);
        locked      = (state_q == ST_LOCKED);
        dbg_state_o = state_q;
    end

    // Result register; values are held after consumption so outputs never go X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_a_q     <= 1'b0;
            out_b_q     <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_a_q     <= dec_a;
            out_b_q     <= dec_b;
            out_err_q   <= !dec_legal;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else if (clr) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else if (accept) begin
            if (dec_legal) begin
                cnt_ok_q <= ok_inc;
            end else begin
                cnt_err_q <= err_inc;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_err   = out_err_q;
    assign cnt_ok        = cnt_ok_q;
    assign cnt_err       = cnt_err_q;

endmodule

// File: doc/gate_vector_decoder.md
Name: gate_vector_decoder

Overview:
- Receiving end of the two-input logic-gate vector interface: takes the 7-bit gate result vector (NOT-a, AND, OR, NAND, NOR, XOR, XNOR) and recovers the (a,b) pair that produced it.
- Flags any vector that matches none of the four legal patterns.
- Keeps saturating good/error counts and locks out further input once an error limit is reached.
- Sits downstream of the logic_gate block in self-checking gate test harnesses.

Parameters:
- CNT_W, 8, width of the good and error counters.
- ERR_LIMIT, 4, error count that forces the LOCKED state; 0 disables locking.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  vec is valid this cycle.
- in_ready  output  1  block accepts vec this cycle.
- vec  input  [0:6]  gate vector: vec[0]=~a, [1]=a&b, [2]=a|b, [3]=~(a&b), [4]=~(a|b), [5]=a^b, [6]=~(a^b).
- out_valid  output  1  result register holds a result.
- out_ready  input  1  downstream consumes the result.
- out_a  output  1  decoded a.
- out_b  output  1  decoded b.
- out_err  output  1  vec was not a legal pattern; out_a/out_b are 0.
- cnt_ok  output  CNT_W  saturating count of legal vectors accepted.
- cnt_err  output  CNT_W  saturating count of illegal vectors accepted.
- locked  output  1  block is in LOCKED state.
- clr  input  1  synchronous clear of counters and lock.

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out_a=0, out_b=0, out_err=0, cnt_ok=0, cnt_err=0, locked=0.
- Legal patterns, vec[0..6] written left to right:
  - 1001101 decodes to a=0, b=0.
  - 1011010 decodes to a=0, b=1.
  - 0011010 decodes to a=1, b=0.
  - 0110001 decodes to a=1, b=1.
  - Any other value is illegal: out_err=1, out_a=0, out_b=0.
- Handshake:
  - Accept when in_valid & in_ready.
  - in_ready = (state!=LOCKED) & (!out_valid | out_ready).
  - Result registers one cycle after acceptance (latency 1). out_valid stays high and out_a/out_b/out_err stay stable until out_ready=1.
  - Simultaneous consume and accept in the same cycle loads the new result; out_valid stays 1.
  - Full-throughput streaming is supported when out_ready is held high.
- States:
  - IDLE: no accepted vector since reset or clr. The first accept moves to RUN.
  - RUN: normal operation. An accept that is illegal and brings cnt_err to ERR_LIMIT (when ERR_LIMIT>0) moves to LOCKED on the same edge; that result is still registered and presented.
  - LOCKED: locked=1, in_ready=0. The pending result may still drain. Exit only via clr or rst.
- Counters:
  - cnt_ok increments on a legal accept; cnt_err increments on an illegal accept.
  - Both hold at 2^CNT_W-1; no wrap.
  - If a counter is saturated, the lock compare uses the saturated value.
- clr:
  - Sampled on the clk edge. Sets counters to 0, state to IDLE, locked to 0.
  - Does not disturb out_valid or the held result.
  - clr has priority: a vector accepted in the same cycle is decoded and presented but not counted, and causes no transition to RUN or LOCKED. in_ready is evaluated before clr takes effect.
- rst asserted mid-transfer discards any held result immediately; out_valid drops without the clock.
- No X propagation: out_a/out_b/out_err are held at their last value when out_valid=0.

Test Plan:
- Reset, then apply vec=1001101,1011010,0011010,0110001 back-to-back with out_ready=1 -> out_valid on cycles 1-4 after the first accept, (a,b)=00,01,10,11, out_err=0, cnt_ok=4, cnt_err=0, state RUN.
- vec=1111111 then vec=0000000 -> out_err=1 with out_a=out_b=0 both times, cnt_err=2, locked=0.
- ERR_LIMIT=4, four illegal vectors -> 4th result presented with out_err=1, locked=1 on that edge, in_ready=0. Next in_valid with legal vec is not accepted and cnt_ok is unchanged. clr=1 -> locked=0, cnt_err=0, in_ready=1.
- out_ready=0 with in_valid=1: first vector held stable, in_ready=0. Raise out_ready -> same cycle accepts the second vector, out_valid stays 1, no result lost or duplicated.
- CNT_W=2, five legal vectors -> cnt_ok=3 (saturated, no wrap).
- Assert rst asynchronously between clock edges while out_valid=1 and locked=1 -> out_valid=0, locked=0, counters 0 immediately, before the next clk edge.
